seg_scanner: RTL
================

# seg_scanner

Time-multiplexed driver for a common-anode bank of seven-segment digits. It holds one 8-bit character code per digit, written by a host register interface. It scans the digits in turn, decoding each code through a single shared `lookup7` instance. Between digits it inserts a blanking gap to suppress ghosting. It sits between the memory-mapped peripheral bus and the board's segment and anode pins.

## Interface
Parameters:
- `DIGITS`, 4: number of digits scanned; must be ≥ 1.
- `DWELL`, 1000: clock cycles each digit is driven; must be ≥ 1.
- `BLANK_CYC`, 16: all-off clock cycles before each digit; a value of 0 removes the blank phase.

Ports:
- `clk`, input, 1: sole clock; all state changes on the rising edge.
- `reset`, input, 1: synchronous, active-high.
- `en`, input, 1: scan enable.
- `wr_en`, input, 1: character write strobe.
- `wr_idx`, input, clog2(DIGITS) (min 1): target digit of the write.
- `wr_data`, input, 8: ASCII character code.
- `seg`, output, 7: segments a..g, bit6 = a, bit0 = g, active-high, registered.
- `an_n`, output, DIGITS: digit enables, active-low, registered.
- `frame`, output, 1: one-cycle pulse when the last digit's dwell completes.

## Operation
- Character store:
  - `DIGITS` × 8-bit registers.
  - When `wr_en`=1, `wr_data` is written into entry `wr_idx` at the next edge.
  - A write with `wr_idx` ≥ `DIGITS` is ignored.
  - Every write completes in one cycle; there is no backpressure.
- Decode: there is exactly one `lookup7` instance. Its input is the character register selected by the current scan index `idx`. Unmapped codes decode to 7'b0000000.
- State machine: `IDLE`, `BLANK`, `DRIVE`. There is a down-counter `cnt` sized for max(DWELL, BLANK_CYC), and an index `idx`.
  - `IDLE`: `an_n` is all 1, `seg`=0. When `en`=1, go to `BLANK` (or to `DRIVE` if BLANK_CYC=0) for the current `idx`.
  - `BLANK`: `an_n` is all 1, `seg`=0. The state lasts BLANK_CYC cycles, then goes to `DRIVE`.
  - `DRIVE`:
    - On entry, the decoded pattern for `idx` is captured into `seg`, and `an_n[idx]` is driven to 0.
    - Both are held constant for DWELL cycles.
    - On exit, `idx` advances: if `idx` = DIGITS-1 it wraps to 0 and `frame` pulses; otherwise it increments. The next state is `BLANK` (or `DRIVE` if BLANK_CYC=0).
  - At most one `an_n` bit is 0 in any cycle.
- Write while the target digit is being driven: the register updates, but `seg` keeps its snapshot. The new character appears on the digit's next visit, so no mid-dwell glitch occurs.
- `en` falls in any state: at the next edge go to `IDLE`. `an_n` becomes all 1 and `seg`=0. `idx` is held, and `frame` does not pulse. Scanning resumes at the same `idx` with a full blank phase.
- Reset, synchronous, at any point (including mid-dwell):
  - State returns to `IDLE`; `idx`=0, `cnt`=0.
  - All characters are set to 8'd32 (space, decodes to blank).
  - Outputs: `seg`=0, `an_n` all 1, `frame`=0.
  - Reset wins over a simultaneous `wr_en` or `en`.

## Timing
- All outputs are registered and change on the same edge as the state transition that determines them. There is no combinational path from inputs to outputs.
- Latency from `en` rising (sampled at edge E) to the first `an_n` assertion: BLANK_CYC+1 edges after E. When BLANK_CYC=0 this is 1 edge.
- Per-digit period is BLANK_CYC+DWELL cycles. Frame period is DIGITS×(BLANK_CYC+DWELL).
- `frame` is high for exactly the first cycle after the last `DRIVE` ends, i.e. concurrent with the first `BLANK` cycle of digit 0.
- Write latency: a write becomes visible at the first `DRIVE` entry of that digit that occurs strictly after the write edge.

## Test plan
Configuration: DIGITS=4, DWELL=4, BLANK_CYC=2 unless stated.

- **Reset check:** assert reset for 1 cycle, then hold `en`=1 -> `seg`=0 and `an_n`=4'b1111 throughout reset. The first `DRIVE` shows `seg`=0 (space).
- **Basic scan:** write '0','1','2','3' to idx 0..3, then `en`=1 ->
  - blank 2 cycles, then `an_n`=4'b1110 with `seg`=7'b1111110 for 4 cycles;
  - then blank 2, `an_n`=4'b1101 with `seg`=7'b0110000, and so on;
  - `frame` pulses every 24 cycles.
- **Write mid-dwell:** during idx 1's dwell, write 'A' to idx 1 -> `seg` stays 7'b0110000 until the dwell ends. The next visit shows 7'b1110111. An out-of-range `wr_idx` changes nothing.
- **Disable mid-frame:** drop `en` in the middle of idx 2's dwell -> next edge `an_n`=4'b1111 and `seg`=0, with no `frame` pulse. On re-enable, a 2-cycle blank follows, then idx 2 is driven.
- **Zero blank:** BLANK_CYC=0, DIGITS=1 -> `an_n` is held at 1'b0 continuously and `frame` pulses every 4 cycles.
- **Reset mid-dwell with simultaneous write:** assert reset and `wr_en` in the same cycle -> state `IDLE`, all characters are space, `idx`=0, and the write is discarded.

Source files
------------

// File: rtl/seg_scanner.sv
// Time-multiplexed common-anode seven-segment scanner with host-written character store
// and a single shared ASCII-to-segment decoder.

module lookup7 (
    input  logic [7:0] code,
    output logic [6:0] pat
);

    always_comb begin
        pat = '0;
        unique case (code)
            8'h30:        pat = 7'b1111110; // 0
            8'h31:        pat = 7'b0110000; // 1
            8'h32:        pat = 7'b1101101; // 2
            8'h33:        pat = 7'b1111001; // 3
            8'h34:        pat = 7'b0110011; // 4
            8'h35:        pat = 7'b1011011; // 5
            8'h36:        pat = 7'b1011111; // 6
            8'h37:        pat = 7'b1110000; // 7
            8'h38:        pat = 7'b1111111; // 8
            8'h39:        pat = 7'b1111011; // 9
            8'h41, 8'h61: pat = 7'b1110111; // A
            8'h42, 8'h62: pat = 7'b0011111; // b
            8'h43, 8'h63: pat = 7'b1001110; // C
            8'h44, 8'h64: pat = 7'b0111101; // d
            8'h45, 8'h65: pat = 7'b1001111; // E
            8'h46, 8'h66: pat = 7'b1000111; // F
            8'h48, 8'h68: pat = 7'b0110111; // H
            8'h4c, 8'h6c: pat = 7'b0001110; // L
            8'h50, 8'h70: pat = 7'b1100111; // P
            8'h55, 8'h75: pat = 7'b0111110; // U
            8'h2d:        pat = 7'b0000001; // -
            8'h5f:        pat = 7'b0001000; // _
            default:      pat = '0;
        endcase
    end

endmodule

module seg_scanner #(
    parameter int DIGITS    = 4,
    parameter int DWELL     = 1000,
    parameter int BLANK_CYC = 16,
    localparam int IW       = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              wr_en,
    input  logic [IW-1:0]     wr_idx,
    input  logic [7:0]        wr_data,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] an_n,
    output logic              frame
);

    localparam int MAXC = (DWELL > BLANK_CYC) ? DWELL : BLANK_CYC;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

    state_t            state, state_d;
    logic [CW-1:0]     cnt, cnt_d;
    logic [IW-1:0]     idx, idx_d;
    logic              load, wrap;
    logic [7:0]        chars [DIGITS];
    logic [6:0]        pat;
    logic [6:0]        seg_d;
    logic [DIGITS-1:0] an_d;
    logic              frame_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DIGITS; i++) chars[i] <= 8'd32;
        end else if (wr_en && (int'(wr_idx) < DIGITS)) begin
            chars[wr_idx] <= wr_data;
        end
    end

    // Decoder follows the index about to be driven, so back-to-back DRIVE
    // phases (no blank) capture the next digit's pattern on the same edge.
    lookup7 u_lookup7 (
        .code (chars[idx_d]),
        .pat  (pat)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            seg   <= '0;
            an_n  <= '1;
            frame <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            idx   <= idx_d;
            seg   <= seg_d;
            an_n  <= an_d;
            frame <= frame_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        idx_d   = idx;
        load    = 1'b0;
        wrap    = 1'b0;
        if (!en) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (BLANK_CYC == 0) begin
                        state_d = DRIVE;
                        cnt_d   = CW'(DWELL - 1);
                        load    = 1'b1;
                    end else begin
                        state_d = BLANK;
                        cnt_d   = CW'(BLANK_CYC - 1);
                    end
                end
                BLANK: begin
                    if (cnt == '0) begin
                        state_d = DRIVE;
                        cnt_d   = CW'(DWELL - 1);
                        load    = 1'b1;
                    end else begin
                        cnt_d = cnt - CW'(1);
                    end
                end
                DRIVE: begin
                    if (cnt == '0) begin
                        if (idx == IW'(DIGITS - 1)) begin
                            idx_d = '0;
                            wrap  = 1'b1;
                        end else begin
                            idx_d = idx + IW'(1);
                        end
                        if (BLANK_CYC == 0) begin
                            state_d = DRIVE;
                            cnt_d   = CW'(DWELL - 1);
                            load    = 1'b1;
                        end else begin
                            state_d = BLANK;
                            cnt_d   = CW'(BLANK_CYC - 1);
                        end
                    end else begin
                        cnt_d = cnt - CW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        seg_d   = seg;
        an_d    = an_n;
        frame_d = wrap;
        if (state_d != DRIVE) begin
            seg_d = '0;
            an_d  = '1;
        end else if (load) begin
            seg_d        = pat;
            an_d         = '1;
            an_d[idx_d]  = 1'b0;
        end
    end

endmodule
